// File: rtl/dbus_router.sv
// Registered CPU data-bus router: base/mask window decode, one outstanding transfer.
// Define DBUS_TIMEOUT_EN to abort slave transfers stalled for TIMEOUT_CYCLES ACCESS cycles.
module dbus_router #(
  parameter int unsigned                N_SLAVES       = 8,
  parameter int unsigned                ADDR_W         = 32,
  parameter int unsigned                DATA_W         = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_BASE       = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLV_MASK       = '0,
  parameter int unsigned                TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            cpu_address,
  input  logic [DATA_W-1:0]            cpu_data_wr,
  input  logic [DATA_W/8-1:0]          cpu_mask,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  output logic [DATA_W-1:0]            cpu_data_rd,
  output logic                         cpu_stall,
  output logic                         cpu_error,
  output logic [ADDR_W-3:0]            slv_address,
  output logic [DATA_W-1:0]            slv_data_wr,
  output logic [DATA_W/8-1:0]          slv_mask,
  output logic [N_SLAVES-1:0]          slv_read,
  output logic [N_SLAVES-1:0]          slv_write,
  input  logic [N_SLAVES*DATA_W-1:0]   slv_data_rd,
  input  logic [N_SLAVES-1:0]          slv_stall
);

  if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_slaves
    $error("dbus_router: N_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dbus_router: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [N_SLAVES-1:0] hit_sel;
  logic [N_SLAVES-1:0] sel_r;
  logic                is_write_r;
  logic                cpu_req;
  logic                sel_stall;
  logic [DATA_W-1:0]   sel_data;
  logic                tmo_hit;

  assign cpu_req   = cpu_read | cpu_write;
  assign cpu_stall = cpu_req & (state != S_DONE);

  // Scan from the top index down so the lowest matching window wins.
  always_comb begin
    hit_sel = '0;
    for (int unsigned i = N_SLAVES; i > 0; i--) begin
      if ((cpu_address & SLV_MASK[(i-1)*ADDR_W +: ADDR_W]) == SLV_BASE[(i-1)*ADDR_W +: ADDR_W]) begin
        hit_sel        = '0;
        hit_sel[i-1]   = 1'b1;
      end
    end
  end

  always_comb begin
    sel_stall = |(slv_stall & sel_r);
    sel_data  = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (sel_r[i]) begin
        sel_data = sel_data | slv_data_rd[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_inc;

  // tmo_inc is the number of ACCESS cycles spent including the current one.
  assign tmo_inc = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 1'b1;
  assign tmo_hit = sel_stall && (tmo_inc == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == S_IDLE) begin
      tmo_cnt <= '0;
    end else if (state == S_ACCESS) begin
      tmo_cnt <= tmo_inc;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cpu_req) begin
          state_nxt = (|hit_sel) ? S_ACCESS : S_DONE;
        end
      end
      S_ACCESS: begin
        if (!sel_stall || tmo_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_address <= '0;
      slv_data_wr <= '0;
      slv_mask    <= '0;
      slv_read    <= '0;
      slv_write   <= '0;
      sel_r       <= '0;
      is_write_r  <= 1'b0;
      cpu_data_rd <= '0;
      cpu_error   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            slv_address <= cpu_address[ADDR_W-1:2];
            slv_data_wr <= cpu_data_wr;
            slv_mask    <= cpu_mask;
            sel_r       <= hit_sel;
            is_write_r  <= cpu_write;
            slv_write   <= cpu_write ? hit_sel : '0;
            slv_read    <= cpu_write ? '0 : hit_sel;
            cpu_data_rd <= '0;
            cpu_error   <= ~(|hit_sel);
          end
        end
        S_ACCESS: begin
          if (!sel_stall) begin
            slv_read    <= '0;
            slv_write   <= '0;
            cpu_data_rd <= is_write_r ? '0 : sel_data;
            cpu_error   <= 1'b0;
          end else if (tmo_hit) begin
            slv_read    <= '0;
            slv_write   <= '0;
            cpu_data_rd <= '0;
            cpu_error   <= 1'b1;
          end
        end
        S_DONE: begin
          cpu_data_rd <= '0;
          cpu_error   <= 1'b0;
        end
        default: begin
          slv_read  <= '0;
          slv_write <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_router.sv
// Directed, table-driven bench for dbus_router with a stall-programmable slave model.
module tb_dbus_router;

  localparam int unsigned NS  = 8;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned MW  = DW / 8;
  localparam int unsigned TMO = 8;

  // slice 0 is the rightmost word
  localparam logic [NS*AW-1:0] BASES = {
    32'h5000_0000, 32'h3000_0000, 32'hA000_0000, 32'h2000_0000,
    32'h1000_0000, 32'hA000_0000, 32'h9000_0000, 32'h8000_0000};
  localparam logic [NS*AW-1:0] MASKS = {
    32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000,
    32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hF000_0000};

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     cpu_address;
  logic [DW-1:0]     cpu_data_wr;
  logic [MW-1:0]     cpu_mask;
  logic              cpu_read;
  logic              cpu_write;
  logic [DW-1:0]     cpu_data_rd;
  logic              cpu_stall;
  logic              cpu_error;
  logic [AW-3:0]     slv_address;
  logic [DW-1:0]     slv_data_wr;
  logic [MW-1:0]     slv_mask;
  logic [NS-1:0]     slv_read;
  logic [NS-1:0]     slv_write;
  logic [NS*DW-1:0]  slv_data_rd;
  logic [NS-1:0]     slv_stall;

  int unsigned total;
  int unsigned bad;
  int unsigned stall_cfg [NS];
  int unsigned scnt [NS];

  dbus_router #(
    .N_SLAVES       (NS),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .SLV_BASE       (BASES),
    .SLV_MASK       (MASKS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_address (cpu_address),
    .cpu_data_wr (cpu_data_wr),
    .cpu_mask    (cpu_mask),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_data_rd (cpu_data_rd),
    .cpu_stall   (cpu_stall),
    .cpu_error   (cpu_error),
    .slv_address (slv_address),
    .slv_data_wr (slv_data_wr),
    .slv_mask    (slv_mask),
    .slv_read    (slv_read),
    .slv_write   (slv_write),
    .slv_data_rd (slv_data_rd),
    .slv_stall   (slv_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: stalls for stall_cfg[i] cycles of a continuous strobe.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (slv_read[i] | slv_write[i]) scnt[i] <= scnt[i] + 1;
      else                            scnt[i] <= 0;
    end
  end

  always_comb begin
    slv_stall = '0;
    for (int j = 0; j < NS; j++) begin
      slv_stall[j] = (slv_read[j] | slv_write[j]) && (scnt[j] < stall_cfg[j]);
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        rd;
    logic        wr;
    int unsigned k;
    logic [7:0]  exp_rd;
    logic [7:0]  exp_wr;
    logic [31:0] exp_data;
    logic        exp_err;
    int unsigned exp_stall;
    int unsigned exp_strb;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int unsigned stall_n, strb_n;
    logic [7:0]  seen_rd, seen_wr;
    logic [31:0] cap_a, cap_d, got_data;
    logic [3:0]  cap_m;
    logic        first, done, unstable, got_err;
    for (int i = 0; i < NS; i++) stall_cfg[i] = v.k;
    @(negedge clk);
    cpu_address = v.addr;
    cpu_data_wr = v.wdata;
    cpu_mask    = v.mask;
    cpu_read    = v.rd;
    cpu_write   = v.wr;
    #1;
    stall_n = 0; strb_n = 0; seen_rd = '0; seen_wr = '0;
    cap_a = '0; cap_d = '0; cap_m = '0; got_data = '0; got_err = 1'b0;
    first = 1'b1; done = 1'b0; unstable = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      seen_rd = seen_rd | slv_read;
      seen_wr = seen_wr | slv_write;
      if (|(slv_read | slv_write)) begin
        strb_n++;
        if (first) begin
          cap_a = 32'(slv_address); cap_d = slv_data_wr; cap_m = slv_mask; first = 1'b0;
        end else if (cap_a != 32'(slv_address) || cap_d != slv_data_wr || cap_m != slv_mask) begin
          unstable = 1'b1;
        end
      end
      if (cpu_stall) begin
        stall_n++;
        @(negedge clk);
        #1;
      end else begin
        done     = 1'b1;
        got_data = cpu_data_rd;
        got_err  = cpu_error;
      end
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    chk({tag, ".completed"}, 32'(done), 32'd1);
    chk({tag, ".stall_cycles"}, stall_n, v.exp_stall);
    chk({tag, ".strobe_cycles"}, strb_n, v.exp_strb);
    chk({tag, ".read_strobes"}, 32'(seen_rd), 32'(v.exp_rd));
    chk({tag, ".write_strobes"}, 32'(seen_wr), 32'(v.exp_wr));
    chk({tag, ".data"}, got_data, v.exp_data);
    chk({tag, ".error"}, 32'(got_err), 32'(v.exp_err));
    if (v.exp_strb > 0) begin
      chk({tag, ".slv_address"}, cap_a, 32'(v.addr[31:2]));
      chk({tag, ".slv_data_wr"}, cap_d, v.wdata);
      chk({tag, ".slv_mask"}, 32'(cap_m), 32'(v.mask));
      chk({tag, ".stable"}, 32'(unstable), 32'd0);
    end
  endtask

  vec_t vecs [10];
  vec_t v_again;
`ifdef DBUS_TIMEOUT_EN
  vec_t v_tmo;
`endif

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < NS; i++) begin
      stall_cfg[i] = 0;
      slv_data_rd[i*DW +: DW] = (i == 0) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(i * 257));
    end
    //             addr          wdata         mask     rd    wr    k  exp_rd  exp_wr  exp_data      err  stall strb
    vecs[0] = '{32'h8000_0010, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 0, 8'h01, 8'h00, 32'hDEAD_BEEF, 1'b0, 2, 1};
    vecs[1] = '{32'h1000_0020, 32'h1234_5678, 4'b0011, 1'b0, 1'b1, 4, 8'h00, 8'h08, 32'h0000_0000, 1'b0, 6, 5};
    vecs[2] = '{32'h4000_0000, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 0, 8'h00, 8'h00, 32'h0000_0000, 1'b1, 1, 0};
    vecs[3] = '{32'hA000_0100, 32'hCAFE_F00D, 4'b1111, 1'b1, 1'b1, 0, 8'h00, 8'h04, 32'h0000_0000, 1'b0, 2, 1};
    vecs[4] = '{32'hA100_0008, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 2, 8'h20, 8'h00, 32'hC0DE_0505, 1'b0, 4, 3};
    vecs[5] = '{32'h3001_0000, 32'h0000_0001, 4'b0001, 1'b0, 1'b1, 0, 8'h00, 8'h00, 32'h0000_0000, 1'b1, 1, 0};
    vecs[6] = '{32'h5FFF_FFFC, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 1, 8'h80, 8'h00, 32'hC0DE_0707, 1'b0, 3, 2};
    vecs[7] = '{32'h3000_1234, 32'h0000_0000, 4'b0100, 1'b1, 1'b0, 0, 8'h40, 8'h00, 32'hC0DE_0606, 1'b0, 2, 1};
    vecs[8] = '{32'h2000_0004, 32'hA5A5_5A5A, 4'b1000, 1'b0, 1'b1, 3, 8'h00, 8'h10, 32'h0000_0000, 1'b0, 5, 4};
    vecs[9] = '{32'h9000_0000, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 0, 8'h02, 8'h00, 32'hC0DE_0101, 1'b0, 2, 1};

    rst_n       = 1'b0;
    cpu_address = '0;
    cpu_data_wr = '0;
    cpu_mask    = '0;
    cpu_read    = 1'b0;
    cpu_write   = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.strobes", 32'(slv_read | slv_write), 32'd0);
    chk("reset.cpu_error", 32'(cpu_error), 32'd0);
    chk("reset.cpu_data_rd", cpu_data_rd, 32'd0);
    chk("reset.slv_address", 32'(slv_address), 32'd0);
    chk("reset.slv_data_wr", slv_data_wr, 32'd0);
    chk("reset.slv_mask", 32'(slv_mask), 32'd0);
    chk("reset.cpu_stall", 32'(cpu_stall), 32'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 10; n++) begin
      run_txn(vecs[n], $sformatf("vec%0d", n));
    end

    // Reset asserted in the middle of a stalled ACCESS.
    for (int i = 0; i < NS; i++) stall_cfg[i] = 50;
    @(negedge clk);
    cpu_address = 32'h9000_0040;
    cpu_read    = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid.strobe_before", 32'(slv_read), 32'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid.strobes_async", 32'(slv_read | slv_write), 32'd0);
    cpu_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_mid.cpu_error", 32'(cpu_error), 32'd0);
    chk("rst_mid.cpu_stall", 32'(cpu_stall), 32'd0);
    v_again = vecs[0];
    run_txn(v_again, "after_reset");

`ifdef DBUS_TIMEOUT_EN
    v_tmo = '{32'h9000_0004, 32'h0000_0000, 4'b1111, 1'b1, 1'b0, 1000, 8'h02, 8'h00, 32'h0000_0000, 1'b1, 9, 8};
    run_txn(v_tmo, "timeout");
    run_txn(v_again, "after_timeout");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
